// File: rtl/res_writer.sv
// Result-write stage: buffers upstream results in a small FIFO and writes them
// byte-swapped to consecutive result-memory words, yielding the port to the reader.
module res_writer #(
  parameter int DEPTH      = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [31:0]      baseAddr,
  input  logic [CNT_W-1:0] count,
  input  logic             inValid,
  input  logic [31:0]      inData,
  output logic             inReady,
  input  logic             rdReq,
  output logic             memWEn,
  output logic [31:0]      memAddr,
  output logic [31:0]      memDataOut,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state;
  logic [31:0]                  base_q;
  logic [CNT_W-1:0]             cnt_q, acc, wr;
  logic [FIFO_DEPTH-1:0][31:0]  fifo;
  logic [PW-1:0]                rp, wp;
  logic [PW:0]                  occ;
  logic                         empty, full, push, pop;
  logic [31:0]                  head;
  logic [AW-1:0]                addr_lo;

  assign empty   = (occ == '0);
  assign full    = (occ == (PW+1)'(FIFO_DEPTH));
  assign memWEn  = !empty && !rdReq && (state == RUN || state == DRAIN);
  assign pop     = memWEn;
  // a same-cycle pop frees a slot, so a full FIFO can still take a result
  assign inReady = (state == RUN) && (!full || pop) && (acc < cnt_q);
  assign push    = inValid && inReady;

  assign head       = fifo[rp];
  assign memDataOut = empty ? '0 : {head[7:0], head[15:8], head[23:16], head[31:24]};
  assign addr_lo    = base_q[AW-1:0] + wr[AW-1:0];
  assign memAddr    = 32'(addr_lo);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      base_q <= '0;
      cnt_q  <= '0;
      acc    <= '0;
      wr     <= '0;
      rp     <= '0;
      wp     <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wp  <= wp + PW'(1);
        acc <= acc + CNT_W'(1);
      end
      if (pop) begin
        rp <= rp + PW'(1);
        wr <= wr + CNT_W'(1);
      end
      occ <= occ + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      case (state)
        IDLE: if (start) begin
          base_q <= baseAddr;
          cnt_q  <= count;
          acc    <= '0;
          wr     <= '0;
          state  <= (count == '0) ? DONE : RUN;
        end
        RUN:   if (push && (acc + CNT_W'(1) == cnt_q)) state <= DRAIN;
        DRAIN: if (pop && occ == (PW+1)'(1)) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // payload storage needs no reset: the output is gated by the occupancy count
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= inData;
  end

endmodule

// File: tb/tb_res_writer.sv
// Self-checking bench for res_writer: directed jobs plus randomized jobs,
// checked cycle by cycle against an occupancy/queue reference model.
module tb_res_writer;
  localparam int DEPTH = 128, FD = 4, CNT_W = 8;

  logic             clk = 1'b0, rstN = 1'b0, start = 1'b0, inValid = 1'b0, rdReq = 1'b0;
  logic [31:0]      baseAddr = '0, inData = '0;
  logic [CNT_W-1:0] count = '0;
  logic             inReady, memWEn, busy, done;
  logic [31:0]      memAddr, memDataOut;

  always #5 clk = ~clk;

  res_writer #(.DEPTH(DEPTH), .FIFO_DEPTH(FD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstN(rstN), .start(start), .baseAddr(baseAddr), .count(count),
    .inValid(inValid), .inData(inData), .inReady(inReady), .rdReq(rdReq),
    .memWEn(memWEn), .memAddr(memAddr), .memDataOut(memDataOut),
    .busy(busy), .done(done)
  );

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model state
  bit          in_job = 0, done_next = 0, was_idle;
  logic [31:0] job_base;
  int          job_cnt, acc_m, wr_m, done_seen = 0, ncyc = 0, t_acc0 = 0, t_done = 0;
  logic [31:0] pend_q[$];
  logic [31:0] addr_log[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] src_q[$];
  logic        exp_wen, exp_rdy;
  logic [31:0] ea, ed, dpop;

  always @(negedge clk) begin
    ncyc++;
    if (!rstN) begin
      chk("rst_memWEn", memWEn, 0);
      chk("rst_busy", busy, 0);
      in_job = 0;
      done_next = 0;
      pend_q.delete();
    end else begin
      was_idle = !in_job;
      exp_wen  = in_job && (acc_m - wr_m > 0) && !rdReq;
      exp_rdy  = in_job && (acc_m < job_cnt) && ((acc_m - wr_m < FD) || exp_wen);
      chk("memWEn", memWEn, exp_wen);
      chk("inReady", inReady, exp_rdy);
      chk("busy", busy, in_job);
      chk("done", done, done_next);
      if (done) begin
        done_seen++;
        t_done = ncyc;
      end
      if (done_next) begin
        done_next = 0;
        in_job = 0;
      end
      if (exp_wen) begin
        ea   = (job_base + 32'(wr_m)) % 32'(DEPTH);
        dpop = pend_q.pop_front();
        ed   = {<<8{dpop}};
        chk("memAddr", memAddr, ea);
        chk("memDataOut", memDataOut, ed);
        mem_m[ea] = memDataOut;
        addr_log.push_back(memAddr);
        wr_m++;
        if (wr_m == job_cnt) done_next = 1;
      end
      if (exp_rdy && inValid) begin
        if (acc_m == 0) t_acc0 = ncyc;
        pend_q.push_back(inData);
        acc_m++;
      end
      if (start && was_idle) begin
        job_base = baseAddr;
        job_cnt  = int'(count);
        acc_m    = 0;
        wr_m     = 0;
        in_job   = 1;
        if (count == '0) done_next = 1;
      end
    end
  end

  // mode 0: back-to-back, 1: valid toggling, 2: rdReq window, 3: random valid/rdReq
  task automatic run_job(input logic [31:0] base, input int cnt, input int mode, input int restart_at);
    int sent, cyc, d0;
    bit fire, need;
    sent = 0; cyc = 0; fire = 0; need = 1;
    d0 = done_seen;
    addr_log.delete();
    @(posedge clk); #1;
    start = 1; baseAddr = base; count = CNT_W'(cnt);
    @(posedge clk); #1;
    start = 0; baseAddr = $urandom;
    inValid = 0;
    while (sent < cnt && cyc < 1000) begin
      if (!(inValid && !fire)) begin
        case (mode)
          1:       inValid = !inValid;
          3:       inValid = ($urandom_range(0, 2) != 0);
          default: inValid = 1;
        endcase
        if (inValid && need) begin
          inData = (src_q.size() > 0) ? src_q.pop_front() : $urandom;
          need = 0;
        end
      end
      rdReq = (mode == 2) ? (cyc >= 2 && cyc < 8) :
              (mode == 3) ? ($urandom_range(0, 3) == 0) : 1'b0;
      start = (cyc == restart_at);
      if (start) baseAddr = base + 32'd37;
      @(negedge clk);
      fire = inValid && inReady;
      @(posedge clk); #1;
      if (fire) begin
        sent++;
        need = 1;
      end
      cyc++;
    end
    inValid = 0; start = 0; rdReq = 0;
    for (int i = 0; i < 400 && done_seen == d0; i++) @(posedge clk);
    #1;
    chk("done_pulse", done_seen, d0 + 1);
  endtask

  logic [31:0] tbl [4];
  logic [31:0] r, o;

  initial begin
    tbl[0] = 32'h11223344; tbl[1] = 32'h55667788;
    tbl[2] = 32'h99AABBCC; tbl[3] = 32'hDDEEFF00;

    repeat (2) @(posedge clk); #1;
    chk("rst_inReady", inReady, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memDataOut", memDataOut, 0);
    chk("rst_done", done, 0);
    rstN = 1;

    // basic job with known data
    for (int i = 0; i < 4; i++) src_q.push_back(tbl[i]);
    run_job(32'd0, 4, 0, -1);
    chk("basic_latency", t_done - t_acc0, 5);
    chk("basic_nwrites", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      r = mem_m[i];
      o = {<<8{r}};
      chk("basic_stored", r, (i == 0) ? 32'h44332211 : (i == 1) ? 32'h88776655 :
                             (i == 2) ? 32'hCCBBAA99 : 32'h00FFEEDD);
      chk("basic_readback", o, tbl[i]);
    end

    // wrap-around
    run_job(32'd126, 4, 0, -1);
    chk("wrap_nwrites", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("wrap_addr", addr_log[i], (126 + i) % DEPTH);

    // port contention
    run_job(32'd50, 8, 2, -1);
    chk("contend_nwrites", addr_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("contend_addr", addr_log[i], 50 + i);

    // upstream gaps
    run_job(32'd7, 3, 1, -1);
    chk("gaps_nwrites", addr_log.size(), 3);

    // zero-length job
    run_job(32'd5, 0, 0, -1);
    chk("zero_nwrites", addr_log.size(), 0);

    // start pulsed mid-job must be ignored
    run_job(32'd10, 5, 0, 2);
    chk("ignstart_nwrites", addr_log.size(), 5);
    for (int i = 0; i < 5; i++) chk("ignstart_addr", addr_log[i], 10 + i);

    // reset mid-job with FIFO holding two entries
    @(posedge clk); #1;
    start = 1; baseAddr = 32'd20; count = CNT_W'(6);
    @(posedge clk); #1;
    start = 0; rdReq = 1; inValid = 1; inData = $urandom;
    @(posedge clk); #1;
    inData = $urandom;
    @(posedge clk); #1;
    inValid = 0;
    rstN = 0; rdReq = 0;
    #1;
    chk("midrst_inReady", inReady, 0);
    chk("midrst_memWEn", memWEn, 0);
    chk("midrst_memAddr", memAddr, 0);
    chk("midrst_memDataOut", memDataOut, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 rstN = 1;
    run_job(32'd40, 6, 0, -1);
    chk("postrst_nwrites", addr_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("postrst_addr", addr_log[i], 40 + i);

    // randomized jobs
    for (int j = 0; j < 5; j++) begin
      int n;
      n = $urandom_range(1, 20);
      run_job($urandom, n, 3, -1);
      chk("rand_nwrites", addr_log.size(), n);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/res_writer.md
# res_writer

Result-write stage in front of the 128-word result memory. It accepts 32-bit results from the compute datapath over a valid/ready handshake, buffers them in a small FIFO, and writes them to consecutive memory addresses from a programmed base. Data is byte-swapped on write so the memory's byte-reversing read port returns the original value. The memory address port is shared with the downstream reader, so writes yield whenever the reader requests the port.

## Interface

Parameters:
- `DEPTH`, 128: result memory words; power of two.
- `FIFO_DEPTH`, 4: buffer entries; power of two, ≥2.
- `CNT_W`, 8: width of `count`; must hold `DEPTH`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle job start; sampled only in IDLE.
- `baseAddr`  in  32  first word address; sampled with `start`.
- `count`  in  CNT_W  number of results in job (0..DEPTH); sampled with `start`.
- `inValid`  in  1  upstream result valid.
- `inData`  in  32  upstream result.
- `inReady`  out  1  block can accept `inData` this cycle.
- `rdReq`  in  1  reader owns the memory port this cycle; no write allowed.
- `memWEn`  out  1  memory write enable.
- `memAddr`  out  32  memory word address.
- `memDataOut`  out  32  byte-swapped write data.
- `busy`  out  1  job in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when the last result is written.

## Operation

- States:
  - IDLE: `start`=1 latches `baseAddr`, `count` and clears `acc` (accepted) and `wr` (written) counters. If `count`=0, go to DONE; otherwise go to RUN.
  - RUN: accept and write. When `acc` reaches `count` after an accept, go to DRAIN.
  - DRAIN: no accepts. When the FIFO empties after a write, go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
  - RUN→DONE directly when the final accept and final write land on the same edge with the FIFO then empty is not possible. DRAIN is always visited for at least the cycle in which the last entry is written.
- Handshake:
  - `inReady` = (state==RUN) && (FIFO not full || write occurring this cycle) && (`acc` < `count`).
  - A transfer occurs on an edge where `inValid` && `inReady`. `inData` must be held while `inValid`=1 and `inReady`=0.
- Write:
  - `memWEn` = FIFO not empty && !`rdReq` && state ∈ {RUN, DRAIN}.
  - `memAddr` = (`baseAddr_q` + `wr`) mod `DEPTH`; wraps from DEPTH-1 to 0.
  - `memDataOut` = {head[7:0], head[15:8], head[23:16], head[31:24]}. It is 0 when the FIFO is empty.
  - On a write edge, pop the FIFO and increment `wr`.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- `rdReq` may stay high indefinitely. The FIFO fills, `inReady` drops, and no data is lost or reordered.
- `start` while `busy` is ignored.
- Reset, including mid-job: state IDLE, FIFO empty, counters 0, and no write is issued on any edge after `rstN` falls.

## Timing

- Reset values: `inReady`=0, `memWEn`=0, `memAddr`=0, `memDataOut`=0, `busy`=0, `done`=0.
- `start` at edge k: `busy`=1 and `inReady` may be 1 from cycle k+1.
- A result accepted at edge k is at the FIFO head from cycle k+1 if the FIFO was empty. In that case `memWEn`=1 in cycle k+1 (absent `rdReq`), and the memory stores it at edge k+1. Accept-to-store latency is 1 cycle minimum.
- Throughput: 1 result/cycle with `inValid`=1 and `rdReq`=0.
- `done` is high in the cycle after the edge that writes the last word. `busy` drops one cycle later.
- `count`=0: `done` in cycle k+1 and no writes.
- `memWEn`, `memAddr` and `memDataOut` are combinational from registered state and `rdReq` only. There is no path from `inValid` or `inData`.

## Test plan

- Basic job: base=0, count=4, data 0x11223344, 0x55667788, 0x99AABBCC, 0xDDEEFF00 back-to-back. Required: writes to addresses 0..3 with data 0x44332211, …, 0x00FFEEDD; a reading port returns the originals; `done` exactly once, 5 cycles after first accept.
- Wrap-around: base=126, count=4. Required: addresses 126, 127, 0, 1 in order.
- Port contention: count=8, `rdReq`=1 for 6 cycles mid-job. Required: no `memWEn` while `rdReq`=1; `inReady`=0 after 4 buffered; all 8 words stored in order.
- Upstream gaps: `inValid` toggling 1/0 with count=3. Required: exactly 3 writes; `inReady`=0 after the third accept.
- Zero and ignored start: count=0, then `start` pulsed again mid-job with a different base. Required: count=0 gives `done` with no writes; the mid-job `start` has no effect.
- Reset mid-job: `rstN` low after 2 of 6 accepts with FIFO non-empty. Required: outputs at reset values immediately, no further writes, and a new job runs normally.
